instr_fetch_ctrl: RTL and testbench

Fetch controller that sequences the word-addressed instruction memory of the SDLX processor. It owns the fetch PC, issues one memory read per cycle, buffers returned instructions in a 2-entry queue, and presents them to decode with a valid/ready handshake. It handles branch/jump redirects with flush and in-flight squash, and level-sensitive halt. It sits between the instruction memory and the decode stage.

---
 rtl/instr_fetch_ctrl.sv | 78 +++++++
 tb/tb_instr_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: SDLX instruction fetch sequencer with 2-entry decode queue
// Ports: clk/reset (sync, active-high); imem_rd/imem_addr/imem_data to the
// instruction memory (data one cycle after the read); redirect_valid/redirect_pc
// for taken branches; halt blocks new reads; if_valid/if_instr/if_pc/id_ready
// handshake to decode; fetch_fault sticky out-of-range flag.
// Optional feature: define IFETCH_BOUNDS_CHECK_EN to fault on fetch_pc >= MEM_DEPTH.
module instr_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  output logic              fetch_fault
);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] fetch_pc, inflight_pc;
  logic [ADDR_W+31:0] q [2];
  logic [ADDR_W+31:0] nw;
  logic [1:0] count;
  logic inflight, squash, run, redirect, pop, push, room, over, issue;
  always_comb begin
    run = state == RUN;
    redirect = redirect_valid & run;
    if_valid = (count != 2'd0) & !redirect_valid & !reset;
    pop = if_valid & id_ready;
    push = inflight & !squash & !redirect;
    // occupancy after this cycle's pop, counting the word still on its way
    room = (count + {1'b0, inflight} - {1'b0, pop}) < 2'd2;
`ifdef IFETCH_BOUNDS_CHECK_EN
    over = fetch_pc >= ADDR_W'(MEM_DEPTH);
    fetch_fault = state == FAULT;
`else
    over = (fetch_pc >= ADDR_W'(MEM_DEPTH)) & 1'b0;
    fetch_fault = 1'b0;
`endif
    issue = run & !halt & !redirect_valid & room & !reset;
    imem_rd = issue & !over;
    imem_addr = fetch_pc;
    state_n = state == BOOT ? RUN : (issue & over) ? FAULT : state;
    nw = {inflight_pc, imem_data};
    if_pc = q[0][ADDR_W+31:32];
    if_instr = q[0][31:0];
  end
  always_ff @(posedge clk)
    if (reset) state <= BOOT;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight_pc <= RESET_PC;
      count <= 2'd0;
      inflight <= 1'b0;
      squash <= 1'b0;
      q[0] <= '0;
      q[1] <= '0;
    end else begin
      inflight <= imem_rd;
      squash <= redirect & inflight;
      if (imem_rd) inflight_pc <= fetch_pc;
      fetch_pc <= redirect ? redirect_pc : imem_rd ? fetch_pc + 1'b1 : fetch_pc;
      count <= redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      // head entry holds its last value when the queue empties
      q[0] <= pop ? (count == 2'd2 ? q[1] : push ? nw : q[0]) : (push && count == 2'd0) ? nw : q[0];
      q[1] <= (push && (count - {1'b0, pop}) == 2'd1) ? nw : q[1];
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: randomized scoreboard bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;
  logic clk = 0, reset = 1, redirect_valid = 0, halt = 0, id_ready = 0;
  logic [31:0] redirect_pc = 0, imem_data = 0;
  logic imem_rd, if_valid, fetch_fault;
  logic [31:0] imem_addr, if_instr, if_pc;
  int checks = 0, errors = 0;
  logic [31:0] exp_pc = 0;
  instr_fetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .fetch_fault(fetch_fault)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction
  always @(posedge clk) imem_data <= imem_rd ? mem_word(imem_addr) : $urandom;
  // decode must see the program-order stream restarting at each redirect target
  always @(negedge clk)
    if (!reset && if_valid && id_ready) begin
      checks++;
      if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL xfer pc=%h instr=%h expected pc=%h instr=%h", if_pc, if_instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc++;
    end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1; redirect_valid = 0; halt = 0;
    cyc;
    reset = 0; exp_pc = 0;
  endtask
  task automatic test_reset;
    id_ready = 1;
    do_reset;
    #2; checks++;
    if ({imem_rd, if_valid, fetch_fault} !== 3'b0 || if_instr !== 0 || if_pc !== 0 || imem_addr !== 0) begin
      errors++; $display("FAIL reset rd=%b v=%b f=%b instr=%h pc=%h addr=%h required all 0", imem_rd, if_valid, fetch_fault, if_instr, if_pc, imem_addr);
    end
    cyc; #2; checks++;
    if (imem_rd !== 1 || imem_addr !== 0 || if_valid !== 0) begin
      errors++; $display("FAIL first_rd rd=%b addr=%h v=%b required 1 0 0", imem_rd, imem_addr, if_valid);
    end
    cyc; #2; checks++;
    if (if_valid !== 0) begin errors++; $display("FAIL early_valid v=%b required 0", if_valid); end
    cyc; #2; checks++;
    if (if_valid !== 1 || if_pc !== 0) begin
      errors++; $display("FAIL first_valid v=%b pc=%h required 1 0", if_valid, if_pc);
    end
    for (int i = 0; i < 8; i++) begin
      cyc; #2; checks++;
      if (if_valid !== 1) begin errors++; $display("FAIL no_bubble cyc=%0d v=%b required 1", i, if_valid); end
    end
    do_reset;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc;
      #2; checks++;
      if (if_valid !== (i == 3)) begin errors++; $display("FAIL midreset cyc=%0d v=%b required %b", i, if_valid, i == 3); end
    end
  endtask
  task automatic test_stall;
    int reads;
    id_ready = 1;
    do_reset;
    repeat (8) cyc;
    id_ready = 0; reads = 0;
    for (int i = 0; i < 4; i++) begin
      #2; reads += int'(imem_rd); checks++;
      if (if_valid !== 1) begin errors++; $display("FAIL stall_valid cyc=%0d v=%b required 1", i, if_valid); end
      if (i >= 2) begin
        checks++;
        if (imem_rd !== 0) begin errors++; $display("FAIL stall_rd cyc=%0d rd=%b required 0", i, imem_rd); end
      end
      cyc;
    end
    checks++;
    if (reads > 2) begin errors++; $display("FAIL stall_reads got %0d required <=2", reads); end
    id_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #2; checks++;
      if (if_valid !== 1) begin errors++; $display("FAIL resume cyc=%0d v=%b required 1", i, if_valid); end
      cyc;
    end
  endtask
  task automatic test_redirect;
    id_ready = 1;
    do_reset;
    repeat (9) cyc;
    #2; checks++;
    if (imem_rd !== 1) begin errors++; $display("FAIL pre_inflight rd=%b required 1", imem_rd); end
    cyc;
    redirect_valid = 1; redirect_pc = 20; exp_pc = 20;
    #2; checks++;
    if (if_valid !== 0 || imem_rd !== 0) begin errors++; $display("FAIL redir_cycle v=%b rd=%b required 0 0", if_valid, imem_rd); end
    cyc; redirect_valid = 0;
    #2; checks++;
    if (imem_rd !== 1 || imem_addr !== 20 || if_valid !== 0) begin
      errors++; $display("FAIL redir_issue rd=%b addr=%h v=%b required 1 14 0", imem_rd, imem_addr, if_valid);
    end
    cyc; #2; checks++;
    if (if_valid !== 0) begin errors++; $display("FAIL redir_gap v=%b required 0", if_valid); end
    cyc; #2; checks++;
    if (if_valid !== 1 || if_pc !== 20) begin errors++; $display("FAIL redir_land v=%b pc=%h required 1 14", if_valid, if_pc); end
    repeat (3) cyc;
  endtask
  task automatic test_halt;
    id_ready = 1;
    do_reset;
    repeat (7) cyc;
    halt = 1;
    for (int i = 0; i < 5; i++) begin
      #2; checks++;
      if (imem_rd !== 0) begin errors++; $display("FAIL halt_rd cyc=%0d rd=%b required 0", i, imem_rd); end
      if (i >= 3) begin
        checks++;
        if (if_valid !== 0) begin errors++; $display("FAIL halt_drain cyc=%0d v=%b required 0", i, if_valid); end
      end
      cyc;
    end
    halt = 0;
    #2; checks++;
    if (imem_rd !== 1 || imem_addr !== exp_pc) begin
      errors++; $display("FAIL halt_resume rd=%b addr=%h required 1 %h", imem_rd, imem_addr, exp_pc);
    end
    cyc; cyc; #2; checks++;
    if (if_valid !== 1 || if_pc !== exp_pc) begin
      errors++; $display("FAIL halt_land v=%b pc=%h required 1 %h", if_valid, if_pc, exp_pc);
    end
    repeat (3) cyc;
  endtask
`ifndef IFETCH_BOUNDS_CHECK_EN
  task automatic test_wrap;
    id_ready = 1;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF; exp_pc = 32'hFFFF_FFFF;
    cyc; redirect_valid = 0;
    #2; checks++;
    if (imem_rd !== 1 || imem_addr !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_hi rd=%b addr=%h required 1 ffffffff", imem_rd, imem_addr);
    end
    cyc; #2; checks++;
    if (imem_rd !== 1 || imem_addr !== 0) begin
      errors++; $display("FAIL wrap_lo rd=%b addr=%h required 1 00000000", imem_rd, imem_addr);
    end
    repeat (4) cyc;
  endtask
`endif
  task automatic test_random;
    int since;
    logic got;
    id_ready = 1;
    do_reset;
    cyc;
    since = 0;
    for (int n = 0; n < 400; n++) begin
      id_ready = $urandom_range(0, 3) != 0;
      halt = $urandom_range(0, 4) == 0;
      if ($urandom_range(0, 7) == 0 || since >= 8) begin
        redirect_valid = 1;
`ifdef IFETCH_BOUNDS_CHECK_EN
        redirect_pc = $urandom_range(0, 15);
`else
        redirect_pc = $urandom;
`endif
        exp_pc = redirect_pc; since = 0;
      end else begin
        redirect_valid = 0; since++;
      end
      #2;
      if (halt || redirect_valid) begin
        checks++;
        if (imem_rd !== 0) begin errors++; $display("FAIL rand_block n=%0d rd=%b required 0", n, imem_rd); end
      end
      if (redirect_valid) begin
        checks++;
        if (if_valid !== 0) begin errors++; $display("FAIL rand_redir_v n=%0d v=%b required 0", n, if_valid); end
      end
      cyc;
    end
    halt = 0; redirect_valid = 0; id_ready = 1; got = 0;
    for (int i = 0; i < 6; i++) begin
      #2; if (if_valid) got = 1;
      cyc;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rand_live v=0 within 6 cycles required 1"); end
  endtask
`ifdef IFETCH_BOUNDS_CHECK_EN
  task automatic test_fault;
    int n;
    id_ready = 1;
    do_reset;
    cyc;
    redirect_valid = 1; redirect_pc = 30; exp_pc = 30;
    cyc; redirect_valid = 0; n = 0;
    for (int i = 0; i < 12; i++) begin
      #2; checks++;
      if (imem_rd && imem_addr >= 32) begin errors++; $display("FAIL fault_rd addr=%h required no read >= 32", imem_addr); end
      if (if_valid && id_ready) n++;
      cyc;
    end
    checks++;
    if (n != 2 || fetch_fault !== 1) begin errors++; $display("FAIL fault_state words=%0d f=%b required 2 1", n, fetch_fault); end
    redirect_valid = 1; redirect_pc = 5;
    cyc; redirect_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #2; checks++;
      if (imem_rd !== 0 || if_valid !== 0 || fetch_fault !== 1) begin
        errors++; $display("FAIL fault_hold rd=%b v=%b f=%b required 0 0 1", imem_rd, if_valid, fetch_fault);
      end
      cyc;
    end
  endtask
`endif
  initial begin
    test_reset;
    test_stall;
    test_redirect;
    test_halt;
`ifndef IFETCH_BOUNDS_CHECK_EN
    test_wrap;
`endif
    test_random;
`ifdef IFETCH_BOUNDS_CHECK_EN
    test_fault;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
